// File: rtl/signed_div4_seq.sv
// Multi-cycle signed divider: restoring division on operand magnitudes, one quotient bit
// per clock, with sign fix-up, divide-by-zero and overflow reporting.
module signed_div4_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CALC = 3'd1,
      S_FIX  = 3'd2,
      S_ZERO = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Unsigned magnitude of a two's-complement value; -2^(W-1) maps to 2^(W-1).
   function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] m;
      if (v[WIDTH-1]) begin
         m = ~v + WIDTH'(1);
      end else begin
         m = v;
      end
      return m;
   endfunction

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvd_mag;
   logic [WIDTH:0]   r_dvs_mag;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_ovf;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_by_zero;
   logic             r_overflow;

   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic             w_diff_neg;

   // Trial subtract as add of the inverted divisor with carry-in 1; the partial remainder
   // always stays below 2*|divisor|, so WIDTH+1 bits hold the signed difference.
   assign w_rem_sh   = {r_rem, r_dvd_mag[WIDTH-1]};
   assign w_diff     = w_rem_sh + ~r_dvs_mag + (WIDTH+1)'(1);
   assign w_diff_neg = w_diff[WIDTH];

   // Control FSM, iteration datapath and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_dvd         <= '0;
         r_dvd_mag     <= '0;
         r_dvs_mag     <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_neg_q       <= 1'b0;
         r_neg_r       <= 1'b0;
         r_ovf         <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_dvd         <= dividend;
                  r_dvd_mag     <= f_mag(dividend);
                  r_dvs_mag     <= {1'b0, f_mag(divisor)};
                  r_rem         <= '0;
                  r_quo         <= '0;
                  r_cnt         <= CW'(WIDTH);
                  r_neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_neg_r       <= dividend[WIDTH-1];
                  r_ovf         <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                   (divisor == {WIDTH{1'b1}});
                  r_div_by_zero <= 1'b0;
                  r_overflow    <= 1'b0;
                  r_busy        <= 1'b1;
                  r_state       <= (divisor == {WIDTH{1'b0}}) ? S_ZERO : S_CALC;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CALC: begin
               r_dvd_mag <= {r_dvd_mag[WIDTH-2:0], 1'b0};
               r_quo     <= {r_quo[WIDTH-2:0], ~w_diff_neg};
               if (!w_diff_neg) begin
                  r_rem <= w_diff[WIDTH-1:0];
               end else begin
                  r_rem <= w_rem_sh[WIDTH-1:0];
               end
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= S_FIX;
               end else begin
                  r_state <= S_CALC;
               end
            end
            S_FIX: begin
               // Overflow needs no special case: |q| = 2^(W-1) truncates to -2^(W-1).
               r_quotient  <= r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
               r_remainder <= r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;
               r_overflow  <= r_ovf;
               r_busy      <= 1'b0;
               r_done      <= 1'b1;
               r_state     <= S_DONE;
            end
            S_ZERO: begin
               r_quotient    <= {WIDTH{1'b1}};
               r_remainder   <= r_dvd;
               r_div_by_zero <= 1'b1;
               r_busy        <= 1'b0;
               r_done        <= 1'b1;
               r_state       <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_div_by_zero;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_signed_div4_seq.sv
// Randomized self-checking bench for signed_div4_seq against an integer-arithmetic model.
module tb_signed_div4_seq;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic         overflow;

   int           n_checks;
   int           n_errors;
   logic [W-1:0] prev_q;

   signed_div4_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed integer division, truncating toward zero.
   task automatic model(input int a, input int b, output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output logic ov);
      int qi;
      int ri;
      dz = 1'b0;
      ov = 1'b0;
      if (b == 0) begin
         qi = -1;
         ri = a;
         dz = 1'b1;
      end else begin
         qi = a / b;
         ri = a % b;
         ov = (a == -(1 << (W - 1))) && (b == -1);
      end
      q = qi[W-1:0];
      r = ri[W-1:0];
   endtask

   // Called at #1 after an edge with the DUT idle; returns #1 after the edge following done.
   task automatic run_op(input int a, input int b, input bit repulse, input bit poke_done);
      logic [W-1:0] eq, er;
      logic         edz, eov;
      int           n;
      int           lat;
      model(a, b, eq, er, edz, eov);
      lat = (b == 0) ? 1 : W + 1;
      dividend = a[W-1:0];
      divisor  = b[W-1:0];
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      check("busy_after_start", busy, 1'b1);
      check("flags_cleared", {div_by_zero, overflow}, 2'b00);
      check("quotient_held", quotient, prev_q);
      n = 0;
      while (n < 3 * W + 8) begin
         if (repulse && n == 1) begin
            dividend = W'(1);
            divisor  = W'(1);
            start    = 1'b1;
         end
         @(posedge clk);
         n++;
         #1;
         start = 1'b0;
         if (done) break;
         check("busy_during_op", busy, 1'b1);
      end
      check("done_latency", n, lat);
      check("busy_at_done", busy, 1'b0);
      check("quotient", quotient, eq);
      check("remainder", remainder, er);
      check("div_by_zero", div_by_zero, edz);
      check("overflow", overflow, eov);
      prev_q = eq;
      if (poke_done) begin
         dividend = W'($urandom);
         divisor  = W'($urandom);
         start    = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check("done_one_cycle", done, 1'b0);
      if (poke_done) check("start_in_done_ignored", busy, 1'b0);
   endtask

   initial begin
      bit seen_done;
      n_checks = 0;
      n_errors = 0;
      prev_q   = '0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #3;
      check("reset_outputs", {busy, done, quotient, remainder, div_by_zero, overflow}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(7, 2, 1'b0, 1'b0);
      run_op(-7, 2, 1'b0, 1'b0);
      run_op(3, -4, 1'b0, 1'b0);
      run_op(5, 0, 1'b0, 1'b1);
      run_op(-8, -1, 1'b0, 1'b0);
      run_op(6, 3, 1'b0, 1'b0);
      run_op(6, 3, 1'b1, 1'b0);

      // Asynchronous reset in the middle of an operation.
      dividend = W'(6);
      divisor  = W'(3);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_mid_op", {busy, done, quotient, remainder, div_by_zero, overflow}, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      prev_q = '0;
      seen_done = 1'b0;
      for (int i = 0; i < W + 6; i++) begin
         @(posedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      check("no_done_after_reset", seen_done, 1'b0);

      for (int i = 0; i < 60; i++) begin
         int a, b;
         a = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
         case ($urandom_range(0, 5))
            0:       b = 0;
            1:       b = -1;
            default: b = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
         endcase
         if ($urandom_range(0, 7) == 0) a = -(1 << (W - 1));
         run_op(a, b, bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
